// File: rtl/pe_port_requester.sv
// Engine-side initiator for one LVT memory port: registers the port strobes and returns
// read data in issue order through a response FIFO. Read issue is limited by credits.
module pe_port_requester #(
    parameter int index_width     = 8,
    parameter int data_width      = 64,
    parameter int read_latency    = 3,
    parameter int max_outstanding = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [index_width-1:0] req_addr,
    input  logic [data_width-1:0]  req_kandv,
    output logic                   port_wen,
    output logic                   port_ren,
    output logic [index_width-1:0] port_addr,
    output logic [data_width-1:0]  port_write_kandv,
    input  logic [data_width-1:0]  port_read_kandv,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [data_width-1:0]  rsp_kandv,
    output logic                   busy
);
    localparam int CNT_W = $clog2(max_outstanding + 1);
    localparam int PTR_W = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(max_outstanding);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(max_outstanding - 1);

    logic                    port_wen_q, port_wen_d;
    logic                    port_ren_q, port_ren_d;
    logic [index_width-1:0]  port_addr_q, port_addr_d;
    logic [data_width-1:0]   port_wdata_q, port_wdata_d;
    logic [read_latency-1:0] rd_vld_q, rd_vld_d;
    logic [CNT_W-1:0]        credit_q, credit_d;
    logic [CNT_W-1:0]        fill_q, fill_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [data_width-1:0]   fifo_mem [max_outstanding];
    logic                    accept, accept_rd, accept_wr, push, pop, full;

    // A credit covers a read from acceptance until its response is popped.
    assign req_ready = !reset && (req_write || (credit_q < MAX_CNT));
    assign accept    = req_valid && req_ready;
    assign accept_rd = accept && !req_write;
    assign accept_wr = accept && req_write;
    assign push      = rd_vld_q[read_latency-1];
    assign pop       = rsp_valid && rsp_ready;
    assign full      = (fill_q == MAX_CNT);

    assign port_wen         = port_wen_q;
    assign port_ren         = port_ren_q;
    assign port_addr        = port_addr_q;
    assign port_write_kandv = port_wdata_q;
    assign rsp_valid        = (fill_q != '0);
    assign rsp_kandv        = fifo_mem[rd_ptr_q];
    assign busy             = (credit_q != '0);

    assign rd_vld_d[0] = port_ren_q;
    genvar gi;
    generate
        for (gi = 1; gi < read_latency; gi++) begin : g_rd_vld
            assign rd_vld_d[gi] = rd_vld_q[gi-1];
        end
    endgenerate

    always_comb begin
        port_wen_d   = accept_wr;
        port_ren_d   = accept_rd;
        port_addr_d  = accept ? req_addr : port_addr_q;
        port_wdata_d = accept_wr ? req_kandv : port_wdata_q;

        credit_d = credit_q;
        if (accept_rd && !pop) begin
            credit_d = credit_q + 1'b1;
        end else if (pop && !accept_rd) begin
            credit_d = credit_q - 1'b1;
        end

        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (pop && !push) begin
            fill_d = fill_q - 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            port_wen_q   <= 1'b0;
            port_ren_q   <= 1'b0;
            port_addr_q  <= '0;
            port_wdata_q <= '0;
            rd_vld_q     <= '0;
            credit_q     <= '0;
            fill_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            port_wen_q   <= port_wen_d;
            port_ren_q   <= port_ren_d;
            port_addr_q  <= port_addr_d;
            port_wdata_q <= port_wdata_d;
            rd_vld_q     <= rd_vld_d;
            credit_q     <= credit_d;
            fill_q       <= fill_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // When full, the write slot equals the head slot; the head is consumed this same edge.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr_q] <= port_read_kandv;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full && !pop))
                else $error("pe_port_requester: push into full response FIFO");
        end
    end
endmodule

// File: tb/tb_pe_port_requester.sv
// Bench for pe_port_requester: directed steps then random traffic, checked each cycle
// against a transaction-level model of credits, strobes and in-order responses.
module tb_pe_port_requester;
    localparam int IW = 8;
    localparam int DW = 64;
    localparam int RL = 3;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [IW-1:0] req_addr;
    logic [DW-1:0] req_kandv;
    logic          port_wen, port_ren;
    logic [IW-1:0] port_addr;
    logic [DW-1:0] port_write_kandv, port_read_kandv;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_kandv;
    logic          busy;

    pe_port_requester #(
        .index_width(IW), .data_width(DW), .read_latency(RL), .max_outstanding(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_kandv(req_kandv),
        .port_wen(port_wen), .port_ren(port_ren), .port_addr(port_addr),
        .port_write_kandv(port_write_kandv), .port_read_kandv(port_read_kandv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_kandv(rsp_kandv),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Port environment: returns rd_data_for[addr] exactly RL cycles after a read strobe,
    // random garbage in every other cycle.
    logic [DW-1:0] rd_data_for [256];
    bit            ren_h  [RL+1];
    bit   [IW-1:0] addr_h [RL+1];
    always @(negedge clk) begin
        for (int k = RL; k > 0; k--) begin
            ren_h[k]  = ren_h[k-1];
            addr_h[k] = addr_h[k-1];
        end
        ren_h[0]  = (port_ren === 1'b1);
        addr_h[0] = port_addr;
        port_read_kandv = ren_h[RL] ? rd_data_for[addr_h[RL]] : {$urandom, $urandom};
    end

    // Reference model: each accepted read becomes visible RL+2 cycles after acceptance.
    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } rsp_t;
    rsp_t          exp_q[$];
    int            m_cred = 0;
    int            cyc_n = 0;
    int            n_vec = 0;
    int            n_err = 0;
    logic          e_wen = 1'b0, e_ren = 1'b0;
    logic [IW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_vec++;
        assert (obs === expv)
            else begin
                n_err++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
            end
    endtask

    task automatic cmd(input bit v, input bit w, input logic [IW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_kandv = d;
    endtask

    task automatic tick();
        logic m_ready, m_rvalid, acc, pop;
        #1;
        m_ready  = !reset && (req_write || m_cred < MO);
        m_rvalid = (exp_q.size() != 0) && (exp_q[0].avail <= cyc_n);
        chk("req_ready", req_ready, m_ready);
        chk("rsp_valid", rsp_valid, m_rvalid);
        if (m_rvalid) chk("rsp_kandv", rsp_kandv, exp_q[0].data);
        acc = req_valid && m_ready;
        pop = rsp_ready && m_rvalid;
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            m_cred  = 0;
            e_wen   = 1'b0;
            e_ren   = 1'b0;
            e_addr  = '0;
            e_wdata = '0;
        end else begin
            if (pop) begin
                $display("cyc %0d pop  data=0x%0h", cyc_n, exp_q[0].data);
                void'(exp_q.pop_front());
                m_cred--;
            end
            if (acc) begin
                $display("cyc %0d %s addr=0x%0h data=0x%0h", cyc_n, req_write ? "WR" : "RD",
                         req_addr, req_write ? req_kandv : rd_data_for[req_addr]);
            end
            if (acc && !req_write) begin
                exp_q.push_back('{data: rd_data_for[req_addr], avail: cyc_n + RL + 2});
                m_cred++;
            end
            e_wen = acc && req_write;
            e_ren = acc && !req_write;
            if (acc) e_addr = req_addr;
            if (acc && req_write) e_wdata = req_kandv;
        end
        cyc_n++;
        #1;
        chk("port_wen", port_wen, e_wen);
        chk("port_ren", port_ren, e_ren);
        chk("port_addr", port_addr, e_addr);
        chk("port_write_kandv", port_write_kandv, e_wdata);
        chk("busy", busy, m_cred != 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rd_data_for[i] = {$urandom, $urandom};
        rd_data_for[8'h05] = 64'hBEEF;
        for (int i = 0; i < 4; i++) rd_data_for[8'h21 + i] = 64'(i + 1);

        // Reset held for two cycles
        reset = 1'b1;
        rsp_ready = 1'b0;
        cmd(0, 0, '0, '0);
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("reset_req_ready", req_ready, 1'b0);
        reset = 1'b0;
        tick();
        chk("post_reset_ready", req_ready, 1'b1);

        // Single write
        cmd(1, 1, 8'h12, 64'hDEAD);
        tick();
        chk("wr_port_wen", port_wen, 1'b1);
        chk("wr_port_addr", port_addr, 8'h12);
        chk("wr_port_wdata", port_write_kandv, 64'hDEAD);
        cmd(0, 0, '0, '0);
        tick();
        chk("wr_port_wen_drop", port_wen, 1'b0);
        tick();

        // Single read with fixed latency
        cmd(1, 0, 8'h05, '0);
        tick();
        cmd(0, 0, '0, '0);
        repeat (RL + 1) tick();
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_kandv", rsp_kandv, 64'hBEEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_popped_valid", rsp_valid, 1'b0);
        chk("rd_popped_busy", busy, 1'b0);

        // Fill all credits, stall a fifth read, slip a write past the stall
        for (int i = 0; i < 4; i++) begin
            cmd(1, 0, IW'(8'h21 + i), '0);
            tick();
        end
        cmd(1, 0, 8'h30, '0);
        #1;
        chk("full_req_ready", req_ready, 1'b0);
        tick();
        tick();
        cmd(1, 1, 8'h31, 64'h5A5A);
        tick();
        chk("stall_wr_wen", port_wen, 1'b1);
        chk("stall_wr_addr", port_addr, 8'h31);
        cmd(1, 0, 8'h30, '0);
        repeat (6) tick();
        rsp_ready = 1'b1;
        tick();
        chk("pop_frees_credit", req_ready, 1'b1);
        // Read accepted and pop in the same cycle: credits stay at three
        tick();
        cmd(0, 0, '0, '0);
        #1;
        chk("credit_hold_ready", req_ready, 1'b1);
        chk("credit_hold_busy", busy, 1'b1);
        repeat (12) tick();
        rsp_ready = 1'b0;

        // Reset with two reads in flight
        cmd(1, 0, 8'h40, '0);
        tick();
        cmd(1, 0, 8'h41, '0);
        tick();
        cmd(0, 0, '0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) tick();
        chk("flush_rsp_valid", rsp_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cmd($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                IW'($urandom_range(0, 255)), {$urandom, $urandom});
            rsp_ready = $urandom_range(0, 3) != 0;
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        cmd(0, 0, '0, '0);
        rsp_ready = 1'b1;
        repeat (12) tick();
        chk("drain_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
